// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decoder feeding a registered main/skid buffer.
// Define DECODE_ILLEGAL_EN to enable illegal-instruction detection on out_illegal.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  out_alu_op,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_b_imm,
    output logic        out_a_pc,
    output logic        out_reg_we,
    output logic        out_mem_re,
    output logic        out_mem_we,
    output logic        out_branch,
    output logic        out_jump,
    output logic        out_illegal
);

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111
    } opcode_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  alu_op;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        b_imm;
        logic        a_pc;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        branch;
        logic        jump;
        logic        illegal;
    } dec_t;

    dec_t        dec;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign funct3 = in_inst[14:12];
    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u  = {in_inst[31:12], 12'b0};
    assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.rs1     = in_inst[19:15];
        dec.rs2     = in_inst[24:20];
        dec.rd      = in_inst[11:7];
        case (in_inst[6:0])
            OPC_OP: begin
                dec.alu_op = {1'b0, in_inst[30], funct3};
                dec.reg_we = 1'b1;
            end
            OPC_OP_IMM: begin
                // only SRAI uses inst[30]; ADDI must never turn into a subtract
                dec.alu_op = {1'b0, (funct3 == 3'd5) & in_inst[30], funct3};
                dec.b_imm  = 1'b1;
                dec.reg_we = 1'b1;
                dec.imm    = imm_i;
            end
            OPC_BRANCH: begin
                dec.alu_op = {2'b10, funct3};
                dec.branch = 1'b1;
                dec.imm    = imm_b;
            end
            OPC_LOAD: begin
                dec.b_imm  = 1'b1;
                dec.mem_re = 1'b1;
                dec.reg_we = 1'b1;
                dec.imm    = imm_i;
            end
            OPC_STORE: begin
                dec.b_imm  = 1'b1;
                dec.mem_we = 1'b1;
                dec.imm    = imm_s;
            end
            OPC_LUI: begin
                dec.rs1    = '0;
                dec.b_imm  = 1'b1;
                dec.reg_we = 1'b1;
                dec.imm    = imm_u;
            end
            OPC_AUIPC: begin
                dec.a_pc   = 1'b1;
                dec.b_imm  = 1'b1;
                dec.reg_we = 1'b1;
                dec.imm    = imm_u;
            end
            OPC_JAL: begin
                dec.jump   = 1'b1;
                dec.a_pc   = 1'b1;
                dec.b_imm  = 1'b1;
                dec.reg_we = 1'b1;
                dec.imm    = imm_j;
            end
            OPC_JALR: begin
                dec.jump   = 1'b1;
                dec.b_imm  = 1'b1;
                dec.reg_we = 1'b1;
                dec.imm    = imm_i;
            end
`ifdef DECODE_ILLEGAL_EN
            default: dec.illegal = 1'b1;
`else
            default: ;
`endif
        endcase
`ifdef DECODE_ILLEGAL_EN
        if (in_inst[6:0] == OPC_OP) begin
            if (in_inst[31:25] != 7'b0000000 && in_inst[31:25] != 7'b0100000)
                dec.illegal = 1'b1;
            if (in_inst[31:25] == 7'b0100000 && funct3 != 3'd0 && funct3 != 3'd5)
                dec.illegal = 1'b1;
        end
        if (in_inst[6:0] == OPC_BRANCH && (funct3 == 3'd2 || funct3 == 3'd3))
            dec.illegal = 1'b1;
        if (dec.illegal) begin
            dec.reg_we = 1'b0;
            dec.mem_re = 1'b0;
            dec.mem_we = 1'b0;
        end
`endif
    end

    dec_t main_q, main_d, skid_q, skid_d;
    logic main_valid_q, main_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic in_ready_q, in_ready_d;
    logic consume, accept;

    assign consume = main_valid_q & out_ready;
    assign accept  = in_valid & in_ready_q & ~flush;

    // skid is only ever full while main is full, and a full skid blocks input,
    // so accept and skid_valid_q are never both set
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept)
                    main_d = dec;
            end
        end else if (!main_valid_q) begin
            if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign out_pc      = main_q.pc;
    assign out_alu_op  = main_q.alu_op;
    assign out_imm     = main_q.imm;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_rd      = main_q.rd;
    assign out_b_imm   = main_q.b_imm;
    assign out_a_pc    = main_q.a_pc;
    assign out_reg_we  = main_q.reg_we;
    assign out_mem_re  = main_q.mem_re;
    assign out_mem_we  = main_q.mem_we;
    assign out_branch  = main_q.branch;
    assign out_jump    = main_q.jump;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed table-driven bench for decode_stage plus stall, flush and reset sequences.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_pc, out_imm;
    logic [4:0]  out_alu_op, out_rs1, out_rs2, out_rd;
    logic        out_b_imm, out_a_pc, out_reg_we, out_mem_re, out_mem_we;
    logic        out_branch, out_jump, out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DECODE_ILLEGAL_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_alu_op(out_alu_op), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_b_imm(out_b_imm), .out_a_pc(out_a_pc), .out_reg_we(out_reg_we),
        .out_mem_re(out_mem_re), .out_mem_we(out_mem_we), .out_branch(out_branch),
        .out_jump(out_jump), .out_illegal(out_illegal)
    );

    // flags packed as {b_imm, a_pc, reg_we, mem_re, mem_we, branch, jump, illegal}
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [4:0]  op;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [7:0]  flags;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [127:0] got_fields();
        return {out_pc, out_alu_op, out_imm, out_rs1, out_rs2, out_rd,
                out_b_imm, out_a_pc, out_reg_we, out_mem_re, out_mem_we,
                out_branch, out_jump, out_illegal};
    endfunction

    function automatic logic [127:0] exp_fields(input vec_t v);
        return {v.pc, v.op, v.imm, v.rs1, v.rs2, v.rd, v.flags};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        in_valid = v;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    initial begin
        vecs[0]  = '{32'h40208033, 32'h1000, 5'b01000, 32'h0,        5'd1,  5'd2,  5'd0,  8'h20};
        vecs[1]  = '{32'hFFF00093, 32'h1004, 5'b00000, 32'hFFFFFFFF, 5'd0,  5'd31, 5'd1,  8'hA0};
        vecs[2]  = '{32'h0020C463, 32'h1008, 5'b10100, 32'h8,        5'd1,  5'd2,  5'd8,  8'h04};
        vecs[3]  = '{32'h40525193, 32'h100C, 5'b01101, 32'h405,      5'd4,  5'd5,  5'd3,  8'hA0};
        vecs[4]  = '{32'hFFC32283, 32'h1010, 5'b00000, 32'hFFFFFFFC, 5'd6,  5'd28, 5'd5,  8'hB0};
        vecs[5]  = '{32'h00742623, 32'h1014, 5'b00000, 32'd12,       5'd8,  5'd7,  5'd12, 8'h88};
        vecs[6]  = '{32'h123454B7, 32'h1018, 5'b00000, 32'h12345000, 5'd0,  5'd3,  5'd9,  8'hA0};
        vecs[7]  = '{32'hFFFFF517, 32'h101C, 5'b00000, 32'hFFFFF000, 5'd31, 5'd31, 5'd10, 8'hE0};
        vecs[8]  = '{32'hFF9FF0EF, 32'h1020, 5'b00000, 32'hFFFFFFF8, 5'd31, 5'd25, 5'd1,  8'hE2};
        vecs[9]  = '{32'h00008067, 32'h1024, 5'b00000, 32'h0,        5'd1,  5'd0,  5'd0,  8'hA2};
        vecs[10] = '{32'h0000007F, 32'h1028, 5'b00000, 32'h0,        5'd0,  5'd0,  5'd0,  {7'b0, ILL}};
        vecs[11] = '{32'h4020E033, 32'h102C, 5'b01110, 32'h0,        5'd1,  5'd2,  5'd0,
                     ILL ? 8'h01 : 8'h20};
        vecs[12] = '{32'h0020A463, 32'h1030, 5'b10010, 32'h8,        5'd1,  5'd2,  5'd8,  {7'b0000010, ILL}};

        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, '0, '0);
        repeat (2) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);
        check("reset fields", got_fields(), 0);
        reset = 1'b0;

        // back-to-back stream with out_ready held high: one result per cycle
        for (int i = 0; i <= 13; i++) begin
            if (i > 0) begin
                check($sformatf("vec%0d out_valid", i - 1), out_valid, 1);
                check($sformatf("vec%0d fields", i - 1), got_fields(), exp_fields(vecs[i - 1]));
                check($sformatf("vec%0d in_ready", i - 1), in_ready, 1);
            end
            if (i < 13) drive(1'b1, vecs[i].inst, vecs[i].pc);
            else        drive(1'b0, '0, '0);
            @(negedge clk);
        end
        check("drain out_valid", out_valid, 0);

        // stall: three beats offered with out_ready low
        out_ready = 1'b0;
        drive(1'b1, vecs[0].inst, vecs[0].pc);
        @(negedge clk);
        check("stall A valid", out_valid, 1);
        check("stall A fields", got_fields(), exp_fields(vecs[0]));
        check("stall in_ready after A", in_ready, 1);
        drive(1'b1, vecs[1].inst, vecs[1].pc);
        @(negedge clk);
        check("stall in_ready after B", in_ready, 0);
        check("stall A held 1", got_fields(), exp_fields(vecs[0]));
        drive(1'b1, vecs[2].inst, vecs[2].pc);
        @(negedge clk);
        check("stall in_ready on C", in_ready, 0);
        check("stall A held 2", got_fields(), exp_fields(vecs[0]));
        check("stall valid held", out_valid, 1);
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        @(negedge clk);
        check("drain B valid", out_valid, 1);
        check("drain B fields", got_fields(), exp_fields(vecs[1]));
        check("drain in_ready", in_ready, 1);
        @(negedge clk);
        check("drain empty", out_valid, 0);

        // flush with both entries full and a beat on the input
        out_ready = 1'b0;
        drive(1'b1, vecs[3].inst, vecs[3].pc);
        @(negedge clk);
        drive(1'b1, vecs[4].inst, vecs[4].pc);
        @(negedge clk);
        check("pre-flush in_ready", in_ready, 0);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, vecs[5].inst, vecs[5].pc);
        @(negedge clk);
        check("flush out_valid", out_valid, 0);
        check("flush in_ready", in_ready, 1);
        flush = 1'b0;
        drive(1'b0, '0, '0);
        repeat (2) begin
            @(negedge clk);
            check("flushed beat absent", out_valid, 0);
        end

        // flush wins over a transfer into an empty buffer
        flush = 1'b1;
        drive(1'b1, vecs[6].inst, vecs[6].pc);
        @(negedge clk);
        check("flush blocks accept", out_valid, 0);
        flush = 1'b0;
        drive(1'b0, '0, '0);

        // reset mid-stall, with flush and a beat also present
        out_ready = 1'b0;
        drive(1'b1, vecs[7].inst, vecs[7].pc);
        @(negedge clk);
        drive(1'b1, vecs[8].inst, vecs[8].pc);
        @(negedge clk);
        reset = 1'b1;
        flush = 1'b1;
        drive(1'b1, vecs[9].inst, vecs[9].pc);
        @(negedge clk);
        check("mid-stall reset out_valid", out_valid, 0);
        check("mid-stall reset in_ready", in_ready, 1);
        check("mid-stall reset fields", got_fields(), 0);
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, '0, '0);
        @(negedge clk);
        check("post-reset idle", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
